// File: rtl/arf_fu_scheduler_pkg.sv
// arf_fu_scheduler_pkg: shared op/mode encodings, latencies, fixed-point shift and FSM states
package arf_fu_scheduler_pkg;
  localparam int SHIFT_WIDTH = 8;
  localparam int APPR_BITS = 4;
  localparam logic [31:0] APPR_MASK = ~32'((1 << APPR_BITS) - 1);
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;
  localparam logic MODE_APPR = 1'b0;
  localparam logic MODE_ACC = 1'b1;
  localparam int LAT_ADD = 1;
  localparam int LAT_MUL = 2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
endpackage

// File: rtl/arf_fu_scheduler_units.sv
// arf_fu_scheduler_units: round-robin arbiter plus approximate/accurate add and mul datapaths
module arf_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] elig_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o
);
  // scanning from the far end lets the lowest offset from ptr_i overwrite last
  always_comb begin
    grant_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (elig_i[ptr_i + W'(k)]) begin
        grant_o = '0;
        grant_o[ptr_i + W'(k)] = 1'b1;
      end
    end
  end
endmodule

module add_0
  import arf_fu_scheduler_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  // lower-part OR adder: low bits are ORed and never carry into the upper sum
  assign y_o = {a_i[31:APPR_BITS] + b_i[31:APPR_BITS], a_i[APPR_BITS-1:0] | b_i[APPR_BITS-1:0]};
endmodule

module add_1 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  assign y_o = a_i + b_i;
endmodule

module mul_0
  import arf_fu_scheduler_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  assign y_o = 32'((64'(a_i & APPR_MASK) * 64'(b_i & APPR_MASK)) >> SHIFT_WIDTH);
endmodule

module mul_1
  import arf_fu_scheduler_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  assign y_o = 32'((64'(a_i) * 64'(b_i)) >> SHIFT_WIDTH);
endmodule

// File: rtl/arf_fu_scheduler.sv
// arf_fu_scheduler: in-order round-robin issue of add/mul ops to approximate or accurate units
// ARF_STATS_EN enables the saturating appr_cnt/acc_cnt issue counters (tied to 0 otherwise)
module arf_fu_scheduler
  import arf_fu_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ-1:0]    req_op,
  input  logic [N_REQ-1:0]    req_acc,
  input  logic [32*N_REQ-1:0] req_in_0,
  input  logic [32*N_REQ-1:0] req_in_1,
  output logic [31:0]         out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ID_W-1:0]     out_id,
  output logic                busy,
  output logic [15:0]         appr_cnt,
  output logic [15:0]         acc_cnt
);
  logic [1:0] state_q, state_d;
  logic [ID_W-1:0] rr_q, gidx, s1_id_q, m2_id_q, out_id_q;
  logic s1_v_q, s1_op_q, s1_acc_q, m2_v_q, out_v_q;
  logic [31:0] s1_a_q, s1_b_q, m2_q, out_q;
  logic [31:0] add0_y, add1_y, mul0_y, mul1_y;
  logic [N_REQ-1:0] elig, grant;
  logic stall, accept, s1_add, s1_mul;

  assign stall = out_v_q & ~out_ready;
  assign s1_add = s1_v_q && s1_op_q == OP_ADD;
  assign s1_mul = s1_v_q && s1_op_q == OP_MUL;
  // an add accepted behind a mul still in S1 would reach the output slot together with it
  assign elig = req_valid & (s1_mul ? req_op : '1) & {N_REQ{rst_n & ~stall}};
  assign req_ready = grant;
  assign accept = |grant;

  arf_rr_arbiter #(.N(N_REQ), .W(ID_W)) u_arb (.elig_i(elig), .ptr_i(rr_q), .grant_o(grant));

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++) gidx = grant[i] ? ID_W'(i) : gidx;
  end

  add_0 u_add_0 (.a_i(s1_a_q), .b_i(s1_b_q), .y_o(add0_y));
  add_1 u_add_1 (.a_i(s1_a_q), .b_i(s1_b_q), .y_o(add1_y));
  mul_0 u_mul_0 (.a_i(s1_a_q), .b_i(s1_b_q), .y_o(mul0_y));
  mul_1 u_mul_1 (.a_i(s1_a_q), .b_i(s1_b_q), .y_o(mul1_y));

  always_comb begin
    state_d = state_q == S_IDLE ? (accept ? S_ACTIVE : S_IDLE) :
              state_q == S_HOLD ? (out_ready ? S_ACTIVE : S_HOLD) :
              stall ? S_HOLD :
              (!(s1_v_q | m2_v_q | out_v_q) && !accept) ? S_IDLE : S_ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      s1_v_q   <= 1'b0;
      m2_v_q   <= 1'b0;
      out_v_q  <= 1'b0;
      out_q    <= '0;
      out_id_q <= '0;
    end else begin
      state_q <= state_d;
      if (!stall) begin
        s1_v_q <= accept;
        if (accept) begin
          rr_q     <= gidx + 1'b1;
          s1_op_q  <= req_op[gidx];
          s1_acc_q <= req_acc[gidx];
          s1_id_q  <= gidx;
          s1_a_q   <= req_in_0[32*gidx +: 32];
          s1_b_q   <= req_in_1[32*gidx +: 32];
        end
        m2_v_q <= s1_mul;
        if (s1_mul) begin
          m2_q    <= s1_acc_q ? mul1_y : mul0_y;
          m2_id_q <= s1_id_q;
        end
        out_v_q <= m2_v_q | s1_add;
        if (m2_v_q | s1_add) begin
          out_q    <= m2_v_q ? m2_q : (s1_acc_q ? add1_y : add0_y);
          out_id_q <= m2_v_q ? m2_id_q : s1_id_q;
        end
      end
    end
  end

  assign out = out_q;
  assign out_valid = out_v_q;
  assign out_id = out_id_q;
  assign busy = state_q != S_IDLE;

`ifdef ARF_STATS_EN
  logic [15:0] appr_q, acc_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      appr_q <= '0;
      acc_q  <= '0;
    end else if (accept) begin
      if (req_acc[gidx] == MODE_ACC) acc_q <= acc_q + 16'(acc_q != 16'hFFFF);
      else appr_q <= appr_q + 16'(appr_q != 16'hFFFF);
    end
  end
  assign appr_cnt = appr_q;
  assign acc_cnt = acc_q;
`else
  assign appr_cnt = '0;
  assign acc_cnt = '0;
`endif
endmodule

// File: doc/arf_fu_scheduler.md
ARF_FU_SCHEDULER -- requirements
Module: arf_fu_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (power of 2, 2..8).
REQ-002 SHALL have parameter ID_W, default 2, equal to log2(N_REQ).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have port req_valid, input, N_REQ, per-requester operation valid.
REQ-006 SHALL have port req_ready, output, N_REQ, one-hot-or-zero grant.
REQ-007 SHALL have port req_op, input, N_REQ, per requester: 0 = add, 1 = mul.
REQ-008 SHALL have port req_acc, input, N_REQ, per requester: 0 = approximate unit, 1 = accurate unit.
REQ-009 SHALL have port req_in_0, input, 32*N_REQ, operand A; requester i at bits [32i+31:32i].
REQ-010 SHALL have port req_in_1, input, 32*N_REQ, operand B, same packing.
REQ-011 SHALL have port out, output, 32, result.
REQ-012 SHALL have port out_valid, output, 1, result valid.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts.
REQ-014 SHALL have port out_id, output, ID_W, requester index owning the result.
REQ-015 SHALL have port busy, output, 1, high when the FSM is not IDLE.
REQ-016 SHALL have port appr_cnt, output, 16, approximate operations issued.
REQ-017 SHALL have port acc_cnt, output, 16, accurate operations issued.

Function
REQ-018 SHALL accept requester i on a rising edge where req_valid[i] and req_ready[i] are both 1; req_ready may depend combinationally on req_valid.
REQ-019 SHALL use round-robin arbitration: grant the lowest eligible index at or after pointer rr_ptr (wrapping), then set rr_ptr to the granted index + 1 mod N_REQ.
REQ-020 SHALL drive req_ready to all-zero while stalled (out_valid=1 and out_ready=0).
REQ-021 SHALL treat an add request as ineligible in the cycle immediately after a mul acceptance (output-slot hazard); a mul request stays eligible.
REQ-022 SHALL capture operands, op, acc and id into issue stage S1 on acceptance.
REQ-023 SHALL compute add results from S1 through add_0 (acc=0) or add_1 (acc=1), register them into the output register one edge after acceptance, and give latency 1.
REQ-024 SHALL compute mul results from S1 through mul_0 (acc=0) or mul_1 (acc=1), register them into stage M2, then into the output register, and give latency 2.
REQ-025 SHALL take mul results in their existing `SHIFT_WIDTH fixed-point form with no further scaling, and take add results as 32-bit wrap-around with carry-out discarded.
REQ-026 SHALL complete results strictly in acceptance order, with out_id equal to the accepted index.
REQ-027 SHALL freeze S1, M2, the output register and rr_ptr while stalled, with no result lost or duplicated.
REQ-028 SHALL implement FSM IDLE -> ACTIVE on acceptance; ACTIVE -> HOLD on stall; HOLD -> ACTIVE when out_ready=1; ACTIVE -> IDLE when no stage is valid and there is no acceptance.
REQ-029 SHALL allow out_valid to fall the edge after acceptance when no new result arrives, and support back-to-back results every cycle.

Reset
REQ-030 SHALL, on rst_n=0 at an edge, clear out, out_id, out_valid, busy, appr_cnt, acc_cnt, rr_ptr and all stage valids to 0, and set the FSM to IDLE.
REQ-031 SHALL discard in-flight operations on reset mid-operation, produce no result for them, and hold req_ready at 0 during the reset cycle.

Configuration
REQ-032 SHALL, with ARF_STATS_EN defined, increment appr_cnt or acc_cnt on each acceptance according to req_acc, saturating at 16'hFFFF.
REQ-033 SHALL, without ARF_STATS_EN, keep appr_cnt and acc_cnt as ports tied to 0 and remove the counter registers.

Structure
REQ-034 SHALL place op encodings (ADD=0, MUL=1), mode encodings (APPR=0, ACC=1) and latency constants in the shared parameters.v header alongside SHIFT_WIDTH.
REQ-035 SHALL implement arbitration in sub-module arf_rr_arbiter (inputs: eligible mask and rr_ptr; output: one-hot grant), and instantiate mul_0, mul_1, add_0 and add_1 once each.

Verification
REQ-036 SHALL cover: single add, requester 2, acc=1, 5+7 -> out=12, out_id=2, out_valid exactly 1 edge after acceptance, busy returns 0.
REQ-037 SHALL cover: all 4 requesters valid continuously with adds -> grants 0,1,2,3,0 on consecutive cycles and out_id in the same order.
REQ-038 SHALL cover: mul from requester 0 then add from requester 1 pending -> requester 1 is not granted the next cycle and is granted one cycle later, with no output collision.
REQ-039 SHALL cover: out_ready=0 for 3 cycles with 2 ops in flight -> req_ready=0, out held stable, both results delivered in order afterward.
REQ-040 SHALL cover: rst_n=0 while a mul is in M2 -> no out_valid for it, all outputs 0 the next cycle.
REQ-041 SHALL cover, with ARF_STATS_EN: 3 approximate and 2 accurate ops -> appr_cnt=3, acc_cnt=2; without the macro both stay 0.
